// File: rtl/display_timer_if.sv
// Video timing bundle: pixel coordinates, sync/enable levels and frame/line strobes.
// Latency: n/a (signal bundle only).
// Backpressure: none; the timing source free-runs and consumers sample every cycle.
//
// Signals:
//   sx, sy     current pixel position (CORDW bits each)
//   hsync      horizontal sync level
//   vsync      vertical sync level
//   de         data enable, high on visible pixels
//   frame      one-cycle strobe on the first pixel of a frame
//   line       one-cycle strobe on the first pixel of a line
//   animate    one-cycle strobe on the first pixel of vertical blanking
//   frame_cnt  frames started since reset (FRAMEW bits, wraps)
//
// Modports:
//   master  the timing generator, which drives everything
//   slave   a consumer, which only reads
interface display_timer_if #(
  parameter int CORDW  = 10,
  parameter int FRAMEW = 16
);
  logic [CORDW-1:0]  sx;
  logic [CORDW-1:0]  sy;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic              frame;
  logic              line;
  logic              animate;
  logic [FRAMEW-1:0] frame_cnt;

  modport master (
    output sx, sy, hsync, vsync, de, frame, line, animate, frame_cnt
  );

  modport slave (
    input  sx, sy, hsync, vsync, de, frame, line, animate, frame_cnt
  );
endinterface

// File: rtl/display_timer.sv
// Display timing generator: raster counters plus sync, data-enable and frame/line/animate strobes.
// Latency: every output is registered and describes the current (sx,sy) pixel with zero skew.
// Backpressure: none; the generator free-runs on clk_pix and never stalls.
//
// Ports:
//   clk_pix  pixel clock; all state updates on its rising edge
//   rst      asynchronous active-high reset; parks the raster on the last
//            pixel of the frame so the first edge after release lands on (0,0)
//   o_vid    display_timer_if.master carrying sx, sy, hsync, vsync, de,
//            frame, line, animate and frame_cnt
module display_timer #(
  parameter int CORDW  = 10,
  parameter int FRAMEW = 16,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst,
  display_timer_if.master  o_vid
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  // Every boundary is cast to the coordinate width once, so all compares
  // below are between equal-width operands.
  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] CORD_ONE = CORDW'(1);
  localparam logic [FRAMEW-1:0] FCNT_ONE = FRAMEW'(1);

  // Registered state; every output is driven straight from one of these.
  logic [CORDW-1:0]  r_sx;
  logic [CORDW-1:0]  r_sy;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_de;
  logic              r_frame;
  logic              r_line;
  logic              r_animate;
  logic [FRAMEW-1:0] r_frame_cnt;

  // Next-pixel position and the decodes of that position.
  logic              w_sx_last;
  logic              w_sy_last;
  logic [CORDW-1:0]  w_sx_nxt;
  logic [CORDW-1:0]  w_sy_nxt;
  logic              w_hs_act;
  logic              w_vs_act;
  logic              w_de_nxt;
  logic              w_line_nxt;
  logic              w_frame_nxt;
  logic              w_animate_nxt;

  // The decodes are computed from the position the counters are about to
  // take, not the one they hold. That way a coordinate and every flag that
  // describes it are loaded on the same edge, so they never skew.
  always_comb begin
    w_sx_last = (r_sx == H_LAST);
    w_sy_last = (r_sy == V_LAST);

    w_sx_nxt = w_sx_last ? '0 : (r_sx + CORD_ONE);
    w_sy_nxt = r_sy;
    if (w_sx_last) begin
      w_sy_nxt = w_sy_last ? '0 : (r_sy + CORD_ONE);
    end

    w_hs_act      = (w_sx_nxt >= HS_START) && (w_sx_nxt < HS_END);
    w_vs_act      = (w_sy_nxt >= VS_START) && (w_sy_nxt < VS_END);
    w_de_nxt      = (w_sx_nxt < H_ACT) && (w_sy_nxt < V_ACT);
    w_line_nxt    = (w_sx_nxt == '0);
    w_frame_nxt   = w_line_nxt && (w_sy_nxt == '0);
    w_animate_nxt = w_line_nxt && (w_sy_nxt == V_ACT);
  end

  // Reset parks the counters on the last pixel of the frame. The first edge
  // after release then wraps them to (0,0) through the ordinary path, and the
  // all-ones frame count rolls over to zero on that same frame strobe. A
  // reset in mid-frame therefore restarts exactly like power-up, and no
  // strobe belonging to the abandoned frame can appear afterwards.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      r_sx        <= H_LAST;
      r_sy        <= V_LAST;
      r_hsync     <= ~H_POL;
      r_vsync     <= ~V_POL;
      r_de        <= 1'b0;
      r_frame     <= 1'b0;
      r_line      <= 1'b0;
      r_animate   <= 1'b0;
      r_frame_cnt <= '1;
    end else begin
      r_sx      <= w_sx_nxt;
      r_sy      <= w_sy_nxt;
      r_hsync   <= w_hs_act ? H_POL : ~H_POL;
      r_vsync   <= w_vs_act ? V_POL : ~V_POL;
      r_de      <= w_de_nxt;
      r_frame   <= w_frame_nxt;
      r_line    <= w_line_nxt;
      r_animate <= w_animate_nxt;
      // Counts on the frame strobe itself, so the value read alongside a
      // frame pulse already includes that frame. Wraps freely.
      if (w_frame_nxt) begin
        r_frame_cnt <= r_frame_cnt + FCNT_ONE;
      end
    end
  end

  assign o_vid.sx        = r_sx;
  assign o_vid.sy        = r_sy;
  assign o_vid.hsync     = r_hsync;
  assign o_vid.vsync     = r_vsync;
  assign o_vid.de        = r_de;
  assign o_vid.frame     = r_frame;
  assign o_vid.line      = r_line;
  assign o_vid.animate   = r_animate;
  assign o_vid.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_display_timer.sv
// Self-checking bench for display_timer. It drives three instances:
//   u_def  default 640x480 timing; reset values, first pixel, hsync/de edges
//   u_sml  16x12 raster, FRAMEW=2; full per-pixel sweep over five frames
//   u_inv  same raster as u_sml with active-high syncs
// u_sml and u_inv share a reset.
module tb_display_timer;

  localparam int S_HRES = 8;
  localparam int S_HFP = 2;
  localparam int S_HSYNC = 3;
  localparam int S_HBP = 3;
  localparam int S_VRES = 6;
  localparam int S_VFP = 2;
  localparam int S_VSYNC = 2;
  localparam int S_VBP = 2;
  localparam int S_HTOT = 16;
  localparam int S_VTOT = 12;
  localparam int S_FRAME = S_HTOT * S_VTOT;

  logic clk;
  logic rst_def;
  logic rst_sml;

  int n_tests;
  int n_fail;

  display_timer_if #(.CORDW(10), .FRAMEW(16)) vid_def ();
  display_timer_if #(.CORDW(10), .FRAMEW(2))  vid_sml ();
  display_timer_if #(.CORDW(10), .FRAMEW(16)) vid_inv ();

  display_timer u_def (
    .clk_pix (clk),
    .rst     (rst_def),
    .o_vid   (vid_def)
  );

  display_timer #(
    .CORDW(10), .FRAMEW(2),
    .H_RES(S_HRES), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
    .V_RES(S_VRES), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_sml (
    .clk_pix (clk),
    .rst     (rst_sml),
    .o_vid   (vid_sml)
  );

  display_timer #(
    .CORDW(10), .FRAMEW(16),
    .H_RES(S_HRES), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
    .V_RES(S_VRES), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_inv (
    .clk_pix (clk),
    .rst     (rst_sml),
    .o_vid   (vid_inv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int fc_seen[5];
  int fc_idx;
  int line_cnt;
  int anim_cnt;

  initial begin
    int ex, ey, efc;
    bit hs_act, vs_act;

    n_tests  = 0;
    n_fail   = 0;
    fc_idx   = 0;
    line_cnt = 0;
    anim_cnt = 0;
    rst_def  = 1'b1;
    rst_sml  = 1'b1;

    // Reset values, held across an edge.
    tick();
    check("rst_def_sx",   32'(vid_def.sx), 799);
    check("rst_def_sy",   32'(vid_def.sy), 524);
    check("rst_def_hs",   32'(vid_def.hsync), 1);
    check("rst_def_vs",   32'(vid_def.vsync), 1);
    check("rst_def_de",   32'(vid_def.de), 0);
    check("rst_def_frm",  32'(vid_def.frame), 0);
    check("rst_def_line", 32'(vid_def.line), 0);
    check("rst_def_anim", 32'(vid_def.animate), 0);
    check("rst_def_fcnt", 32'(vid_def.frame_cnt), 32'hffff);
    check("rst_sml_fcnt", 32'(vid_sml.frame_cnt), 3);
    check("rst_sml_sx",   32'(vid_sml.sx), 15);
    check("rst_sml_sy",   32'(vid_sml.sy), 11);
    check("rst_inv_hs",   32'(vid_inv.hsync), 0);
    check("rst_inv_vs",   32'(vid_inv.vsync), 0);

    // Release mid-cycle; the next edge is the first pixel (cycle 0).
    rst_def = 1'b0;
    rst_sml = 1'b0;
    tick();

    for (int k = 0; k < 5 * S_FRAME; k++) begin
      ex     = k % S_HTOT;
      ey     = (k / S_HTOT) % S_VTOT;
      efc    = (k / S_FRAME) % 4;
      hs_act = (ex >= 10) && (ex < 13);
      vs_act = (ey >= 8) && (ey < 10);

      check($sformatf("sml_sx@%0d", k),   32'(vid_sml.sx), 32'(ex));
      check($sformatf("sml_sy@%0d", k),   32'(vid_sml.sy), 32'(ey));
      check($sformatf("sml_de@%0d", k),   32'(vid_sml.de), 32'((ex < 8) && (ey < 6)));
      check($sformatf("sml_hs@%0d", k),   32'(vid_sml.hsync), 32'(!hs_act));
      check($sformatf("sml_vs@%0d", k),   32'(vid_sml.vsync), 32'(!vs_act));
      check($sformatf("sml_line@%0d", k), 32'(vid_sml.line), 32'(ex == 0));
      check($sformatf("sml_frm@%0d", k),  32'(vid_sml.frame), 32'((ex == 0) && (ey == 0)));
      check($sformatf("sml_anim@%0d", k), 32'(vid_sml.animate), 32'((ex == 0) && (ey == 6)));
      check($sformatf("sml_fcnt@%0d", k), 32'(vid_sml.frame_cnt), 32'(efc));
      check($sformatf("inv_sx@%0d", k),   32'(vid_inv.sx), 32'(ex));
      check($sformatf("inv_hs@%0d", k),   32'(vid_inv.hsync), 32'(hs_act));
      check($sformatf("inv_vs@%0d", k),   32'(vid_inv.vsync), 32'(vs_act));

      if (vid_sml.frame === 1'b1 && fc_idx < 5) begin
        fc_seen[fc_idx] = int'(vid_sml.frame_cnt);
        fc_idx++;
      end
      if (k < S_FRAME && vid_sml.line === 1'b1) line_cnt++;
      if (vid_sml.animate === 1'b1) anim_cnt++;

      // Default-timing spot checks along the first two lines.
      if (k == 0) begin
        check("def_first_sx",   32'(vid_def.sx), 0);
        check("def_first_sy",   32'(vid_def.sy), 0);
        check("def_first_de",   32'(vid_def.de), 1);
        check("def_first_frm",  32'(vid_def.frame), 1);
        check("def_first_line", 32'(vid_def.line), 1);
        check("def_first_anim", 32'(vid_def.animate), 0);
        check("def_first_fcnt", 32'(vid_def.frame_cnt), 0);
      end
      if (k == 639) check("def_de@639",  32'(vid_def.de), 1);
      if (k == 640) check("def_de@640",  32'(vid_def.de), 0);
      if (k == 655) check("def_hs@655",  32'(vid_def.hsync), 1);
      if (k == 656) check("def_hs@656",  32'(vid_def.hsync), 0);
      if (k == 751) check("def_hs@751",  32'(vid_def.hsync), 0);
      if (k == 752) check("def_hs@752",  32'(vid_def.hsync), 1);
      if (k == 799) begin
        check("def_sx@799",   32'(vid_def.sx), 799);
        check("def_line@799", 32'(vid_def.line), 0);
      end
      if (k == 800) begin
        check("def_sx@800",   32'(vid_def.sx), 0);
        check("def_sy@800",   32'(vid_def.sy), 1);
        check("def_line@800", 32'(vid_def.line), 1);
        check("def_frm@800",  32'(vid_def.frame), 0);
        check("def_fcnt@800", 32'(vid_def.frame_cnt), 0);
      end
      tick();
    end

    // Frame counter at successive frame pulses wraps 0,1,2,3,0.
    check("fc_pulses", 32'(fc_idx), 5);
    check("fc_seq0", 32'(fc_seen[0]), 0);
    check("fc_seq1", 32'(fc_seen[1]), 1);
    check("fc_seq2", 32'(fc_seen[2]), 2);
    check("fc_seq3", 32'(fc_seen[3]), 3);
    check("fc_seq4", 32'(fc_seen[4]), 0);
    check("lines_per_frame", 32'(line_cnt), S_VTOT);
    check("animate_total",   32'(anim_cnt), 5);

    // Asynchronous reset of the default instance in mid-line.
    for (int i = 0; i < 1000 && vid_def.sx !== 10'd300; i++) tick();
    check("def_wait_sx300", 32'(vid_def.sx), 300);
    rst_def = 1'b1;
    #1;
    check("arst_def_sx",   32'(vid_def.sx), 799);
    check("arst_def_sy",   32'(vid_def.sy), 524);
    check("arst_def_hs",   32'(vid_def.hsync), 1);
    check("arst_def_de",   32'(vid_def.de), 0);
    check("arst_def_fcnt", 32'(vid_def.frame_cnt), 32'hffff);
    tick();
    check("arst_def_hold_sx", 32'(vid_def.sx), 799);
    rst_def = 1'b0;
    tick();
    check("rel_def_sx",   32'(vid_def.sx), 0);
    check("rel_def_sy",   32'(vid_def.sy), 0);
    check("rel_def_de",   32'(vid_def.de), 1);
    check("rel_def_frm",  32'(vid_def.frame), 1);
    check("rel_def_line", 32'(vid_def.line), 1);
    check("rel_def_anim", 32'(vid_def.animate), 0);
    check("rel_def_fcnt", 32'(vid_def.frame_cnt), 0);

    // Asynchronous reset of the small pair in mid-frame at (5,3).
    for (int i = 0; i < 400 && !(vid_sml.sx === 10'd5 && vid_sml.sy === 10'd3); i++) tick();
    check("sml_wait_sx5", 32'(vid_sml.sx), 5);
    check("sml_wait_sy3", 32'(vid_sml.sy), 3);
    rst_sml = 1'b1;
    #1;
    check("arst_sml_sx",   32'(vid_sml.sx), 15);
    check("arst_sml_sy",   32'(vid_sml.sy), 11);
    check("arst_sml_de",   32'(vid_sml.de), 0);
    check("arst_sml_line", 32'(vid_sml.line), 0);
    check("arst_sml_hs",   32'(vid_sml.hsync), 1);
    check("arst_sml_fcnt", 32'(vid_sml.frame_cnt), 3);
    check("arst_inv_hs",   32'(vid_inv.hsync), 0);
    check("arst_inv_vs",   32'(vid_inv.vsync), 0);
    check("arst_inv_fcnt", 32'(vid_inv.frame_cnt), 32'hffff);
    tick();
    rst_sml = 1'b0;
    tick();
    check("rel_sml_sx",   32'(vid_sml.sx), 0);
    check("rel_sml_sy",   32'(vid_sml.sy), 0);
    check("rel_sml_de",   32'(vid_sml.de), 1);
    check("rel_sml_frm",  32'(vid_sml.frame), 1);
    check("rel_sml_line", 32'(vid_sml.line), 1);
    check("rel_sml_anim", 32'(vid_sml.animate), 0);
    check("rel_sml_fcnt", 32'(vid_sml.frame_cnt), 0);
    check("rel_inv_hs",   32'(vid_inv.hsync), 0);
    check("rel_inv_fcnt", 32'(vid_inv.frame_cnt), 0);
    tick();
    check("rel_sml_sx1",   32'(vid_sml.sx), 1);
    check("rel_sml_frm1",  32'(vid_sml.frame), 0);
    check("rel_sml_line1", 32'(vid_sml.line), 0);
    check("rel_sml_fcnt1", 32'(vid_sml.frame_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_timer.md
DISPLAY_TIMER -- requirements
Module: display_timer

Interface
REQ-001 SHALL have parameter CORDW, default 10, screen coordinate width in bits.
REQ-002 SHALL have parameter FRAMEW, default 16, frame counter width in bits.
REQ-003 SHALL have parameters H_RES=640, H_FP=16, H_SYNC=96, H_BP=48: active width and horizontal porch/sync lengths in pixels.
REQ-004 SHALL have parameters V_RES=480, V_FP=10, V_SYNC=2, V_BP=33: active height and vertical porch/sync lengths in lines.
REQ-005 SHALL have parameters H_POL=0 and V_POL=0: sync active level, 0 = active-low.
REQ-006 clk_pix  input  1  pixel clock; all logic on its rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 sx  output  CORDW  horizontal position of current pixel.
REQ-009 sy  output  CORDW  vertical position of current pixel.
REQ-010 hsync  output  1  horizontal sync.
REQ-011 vsync  output  1  vertical sync.
REQ-012 de  output  1  data enable, high for active pixels.
REQ-013 frame  output  1  one-cycle strobe at first pixel of frame.
REQ-014 line  output  1  one-cycle strobe at first pixel of every line.
REQ-015 animate  output  1  one-cycle strobe at start of vertical blanking.
REQ-016 frame_cnt  output  FRAMEW  count of frames started since reset.

Function
REQ-017 H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (525).
REQ-018 sx increments by 1 each cycle and wraps from H_TOTAL-1 to 0.
REQ-019 sy increments by 1 only on the cycle sx wraps; it wraps from V_TOTAL-1 to 0.
REQ-020 All outputs SHALL be registered and SHALL describe the same (sx,sy) pixel in the same cycle; zero skew between them.
REQ-021 hsync SHALL be at active level (H_POL) iff H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC (656..751), otherwise at !H_POL.
REQ-022 vsync SHALL be at active level (V_POL) iff V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC (490..491), for every sx of those lines.
REQ-023 de SHALL be 1 iff sx < H_RES and sy < V_RES.
REQ-024 line SHALL be 1 iff sx == 0.
REQ-025 frame SHALL be 1 iff sx == 0 and sy == 0.
REQ-026 animate SHALL be 1 iff sx == 0 and sy == V_RES (480); exactly once per frame.
REQ-027 frame_cnt SHALL increment by 1 in the cycle frame is asserted, wrapping modulo 2^FRAMEW without saturation.
REQ-028 Parameter values SHALL be chosen so H_TOTAL-1 and V_TOTAL-1 fit in CORDW bits; no overflow handling is required beyond that.

Reset
REQ-029 While rst is high: sx=H_TOTAL-1, sy=V_TOTAL-1, hsync=!H_POL, vsync=!V_POL, de=0, frame=0, line=0, animate=0, frame_cnt=all ones.
REQ-030 Reset SHALL take effect immediately on assertion regardless of clk_pix, including mid-line or mid-frame.
REQ-031 First rising edge after rst deasserts: sx=0, sy=0, de=1, frame=1, line=1, frame_cnt=0.
REQ-032 Re-asserting rst mid-frame SHALL restart timing identically to power-up; no partial frame strobes afterwards.

Verification
REQ-033 Release reset, 1 edge -> sx=0, sy=0, de=1, frame=1, line=1, animate=0, frame_cnt=0.
REQ-034 Run one full frame (420000 cycles) -> frame pulses exactly at cycles 0 and 420000; frame_cnt=1 at cycle 420000; 525 line pulses per frame.
REQ-035 Line sweep -> de high sx 0..639 on sy<480; hsync low sx 656..751, high at 655 and 752; de low for all sx on sy 480..524.
REQ-036 Frame sweep -> vsync low exactly on sy 490 and 491 (all sx); animate single pulse at sx=0, sy=480.
REQ-037 Set FRAMEW=2, run 5 frames -> frame_cnt sequence 0,1,2,3,0 at successive frame pulses.
REQ-038 Assert rst asynchronously at sx=300, sy=200 -> outputs take reset values before next clk_pix edge; after release behaviour matches REQ-033; with H_POL=1 and V_POL=1, sync levels inverted.
